matrix_operand_sequencer: RTL and testbench
===========================================

# matrix_operand_sequencer

Upstream stage of the 8×8 dot-product unit. It accepts two 8×8 matrices of IEEE-754 single-precision words as a serial word stream. It then issues all 64 row/column operand pairs, one pair per cycle, with a qualifying valid. For each pair, row is one row of A and column is one column of B, so the downstream unit produces the C = A·B results in row-major order.

## Interface
- DIM, 8, matrix dimension; only 8 is supported.
- WORD_W, 32, element width in bits; the block never interprets element values.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- in_data  in  WORD_W  element word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  the block accepts a word; a word transfers when in_valid & in_ready.
- row  out  DIM*WORD_W  A[i][k] in bits [32k+31:32k].
- column  out  DIM*WORD_W  B[k][j] in bits [32k+31:32k].
- validin  out  1  row/column pair valid this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last pair is issued.

## Operation
- States: IDLE, LOAD_A, LOAD_B, ISSUE, DONE.
- IDLE: in_ready = 0. When start = 1, go to LOAD_A.
- LOAD_A: in_ready = 1.
  - Accepted words fill A in row-major order. Word n goes to A[n>>3][n&7].
  - A 7-bit load counter counts accepted words.
  - After the 64th accepted word, clear the counter and go to LOAD_B.
- LOAD_B: identical to LOAD_A, but fills B in row-major order (B[r][c]). After the 64th word, go to ISSUE.
- Word gaps: in_valid may drop at any time. While in_valid is low the counters hold.
- ISSUE: a 6-bit issue counter t runs 0..63, one step per cycle, with i = t[5:3] and j = t[2:0].
  - row = A[i], column = {B[7][j], …, B[0][j]}, validin = 1.
  - There is no backpressure; the downstream unit is fully pipelined.
  - After t = 63 is issued, go to DONE.
- DONE: done = 1, validin = 0. Next cycle, go to IDLE.
- start outside IDLE is ignored.
- in_valid while in_ready = 0 is ignored and the word is dropped.
- Matrix storage holds its contents across operations. Only writes during LOAD_A and LOAD_B change it. rst does not clear it.

## Timing
- Reset values: row = 0, column = 0, validin = 0, in_ready = 0, busy = 0, done = 0. State is IDLE and all counters are 0.
- All outputs are registered.
- start accepted in cycle T: in_ready = 1 and busy = 1 from cycle T+1.
- Last B word accepted in cycle T: in_ready = 0 from T+1. First pair (i = 0, j = 0) has validin = 1 in T+1. Pair t appears in T+1+t.
- done is high in T+65 and busy is low in T+66.
- With a gapless stream, start to done is 1 + 128 + 64 + 1 cycles.
- While validin = 0, row and column hold their last issued values.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values. A partial load is abandoned and the next start restarts from A[0][0].

## Configuration
- KEEP_A_EN: adds input port keep_a (1 bit), sampled together with start.
- With KEEP_A_EN defined:
  - If keep_a = 1 and an A matrix has been fully loaded since reset, IDLE goes directly to LOAD_B and A is reused. This supports the constant DCT coefficient matrix in T·M·Tᵀ.
  - An internal a_valid flag is cleared by rst, set on completion of LOAD_A, and cleared on entry to LOAD_A.
  - If keep_a = 1 and a_valid = 0, the block goes to LOAD_A.
- Without KEEP_A_EN: the port does not exist and every start loads both A and B.

## Structure
- Shared package holds:
  - DIM, WORD_W and the derived VEC_W = DIM*WORD_W;
  - the state enum (IDLE, LOAD_A, LOAD_B, ISSUE, DONE);
  - LOAD_CNT_W = 7 and ISSUE_CNT_W = 6.
- Sub-module matrix_reg_bank8x8, instantiated once for A and once for B.
  - Write port: we, 6-bit waddr, WORD_W data.
  - Read ports: a combinational 8-word row read and an 8-word column read.
  - The sequencer uses the row read of A and the column read of B, and registers both onto the outputs.

## Test plan
- Reset then idle: hold rst 3 cycles, release with start = 0. All outputs stay 0 for 10 cycles and in_ready = 0.
- Gapless load, A = identity, B[r][c] = 8r+c:
  - A diagonal = 32'h3F800000, B written as raw integers.
  - First pair: row lane 0 = 32'h3F800000 and all other lanes 0; column lane k = 8k.
  - Pair t = 9 (i = 1, j = 1): row lane 1 = 32'h3F800000; column lane k = 8k+1.
  - validin is high for exactly 64 cycles, followed by a single done pulse.
- Gappy source: in_valid toggles 1,0,1,0 for the whole load. Every word is accepted exactly once, the issue order is unchanged, and validin first rises one cycle after the 128th accepted word.
- start during ISSUE, and in_valid during ISSUE: no effect; the 64 issued pairs equal the no-interference run.
- Reset mid-LOAD_B after 20 B words:
  - Outputs return to reset values the next cycle.
  - A fresh start followed by 128 words produces correct pairs, with no leftover from the abandoned load.
- KEEP_A_EN:
  - First operation: start with keep_a = 1 just after reset goes to LOAD_A.
  - Second operation: start with keep_a = 1 takes only 64 words, all into B, and row outputs match the earlier A.

Source files
------------

// File: rtl/matrix_operand_sequencer_pkg.sv
// Shared types and sizes for the matrix operand sequencer and its 8x8 register banks.
package matrix_operand_sequencer_pkg;

    localparam int DIM         = 8;
    localparam int WORD_W      = 32;
    localparam int VEC_W       = DIM * WORD_W;
    localparam int LOAD_CNT_W  = 7;
    localparam int ISSUE_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        ISSUE,
        DONE
    } state_t;

endpackage

// File: rtl/matrix_operand_sequencer_bank.sv
// matrix_reg_bank8x8: 64-word element store, one write port, combinational 8-word row and column reads.
module matrix_reg_bank8x8
    import matrix_operand_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [5:0]        waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [2:0]        row_sel,
    input  logic [2:0]        col_sel,
    output logic [VEC_W-1:0]  row_data,
    output logic [VEC_W-1:0]  col_data
);

    // Contents are deliberately not reset so a loaded matrix survives rst.
    logic [WORD_W-1:0] r_mem [DIM*DIM];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    always_comb begin
        row_data = '0;
        col_data = '0;
        for (int k = 0; k < DIM; k++) begin
            row_data[k*WORD_W +: WORD_W] = r_mem[{row_sel, 3'(k)}];
            col_data[k*WORD_W +: WORD_W] = r_mem[{3'(k), col_sel}];
        end
    end

endmodule

// File: rtl/matrix_operand_sequencer.sv
// Loads A then B from a word stream and issues all 64 row/column operand pairs of C = A*B.
// Optional feature macro KEEP_A_EN: adds keep_a to reuse a previously loaded A matrix.
module matrix_operand_sequencer
    import matrix_operand_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef KEEP_A_EN
    input  logic              keep_a,
`endif
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [VEC_W-1:0]  row,
    output logic [VEC_W-1:0]  column,
    output logic              validin,
    output logic              busy,
    output logic              done
);

    state_t                 r_state;
    state_t                 w_next;
    logic [LOAD_CNT_W-1:0]  r_loadCnt;
    logic [ISSUE_CNT_W-1:0] r_issueCnt;
    logic [ISSUE_CNT_W-1:0] w_rdIdx;
    logic                   r_inReady;
    logic                   r_validin;
    logic                   r_busy;
    logic                   r_done;
    logic [VEC_W-1:0]       r_row;
    logic [VEC_W-1:0]       r_column;
    logic                   w_accept;
    logic                   w_loadLast;
    logic                   w_skipA;
    logic [VEC_W-1:0]       w_aRow;
    logic [VEC_W-1:0]       w_bCol;
    logic [VEC_W-1:0]       w_unusedACol;
    logic [VEC_W-1:0]       w_unusedBRow;

`ifdef KEEP_A_EN
    logic r_aValid;
    assign w_skipA = keep_a & r_aValid;
`else
    assign w_skipA = 1'b0;
`endif

    assign w_accept   = in_valid & r_inReady;
    assign w_loadLast = (r_loadCnt == LOAD_CNT_W'(DIM*DIM - 1));
    // Index of the pair that will be on the outputs after the next edge.
    assign w_rdIdx    = (r_state == ISSUE) ? r_issueCnt + 1'b1 : '0;

    matrix_reg_bank8x8 u_bankA (
        .clk      (clk),
        .we       (w_accept && (r_state == LOAD_A)),
        .waddr    (r_loadCnt[5:0]),
        .wdata    (in_data),
        .row_sel  (w_rdIdx[5:3]),
        .col_sel  (3'd0),
        .row_data (w_aRow),
        .col_data (w_unusedACol)
    );

    matrix_reg_bank8x8 u_bankB (
        .clk      (clk),
        .we       (w_accept && (r_state == LOAD_B)),
        .waddr    (r_loadCnt[5:0]),
        .wdata    (in_data),
        .row_sel  (3'd0),
        .col_sel  (w_rdIdx[2:0]),
        .row_data (w_unusedBRow),
        .col_data (w_bCol)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = w_skipA ? LOAD_B : LOAD_A;
            LOAD_A:  if (w_accept && w_loadLast) w_next = LOAD_B;
            LOAD_B:  if (w_accept && w_loadLast) w_next = ISSUE;
            ISSUE:   if (r_issueCnt == '1) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Every output is registered from the next state so it lines up with that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_loadCnt  <= '0;
            r_issueCnt <= '0;
            r_inReady  <= 1'b0;
            r_validin  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_row      <= '0;
            r_column   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_loadCnt <= w_loadLast ? '0 : r_loadCnt + 1'b1;
            end
            r_issueCnt <= (w_next == ISSUE) ? w_rdIdx : '0;
            r_inReady  <= (w_next == LOAD_A) || (w_next == LOAD_B);
            r_validin  <= (w_next == ISSUE);
            r_busy     <= (w_next != IDLE);
            r_done     <= (w_next == DONE);
            if (w_next == ISSUE) begin
                r_row    <= w_aRow;
                r_column <= w_bCol;
            end
        end
    end

`ifdef KEEP_A_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aValid <= 1'b0;
        end else if ((w_next == LOAD_A) && (r_state != LOAD_A)) begin
            r_aValid <= 1'b0;
        end else if ((r_state == LOAD_A) && (w_next == LOAD_B)) begin
            r_aValid <= 1'b1;
        end
    end
`endif

    assign in_ready = r_inReady;
    assign validin  = r_validin;
    assign busy     = r_busy;
    assign done     = r_done;
    assign row      = r_row;
    assign column   = r_column;

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Randomized self-checking bench: matrix model in the bench predicts every issued operand pair.
module tb_matrix_operand_sequencer;
    import matrix_operand_sequencer_pkg::*;

`ifdef KEEP_A_EN
    localparam bit HAS_KEEP = 1'b1;
`else
    localparam bit HAS_KEEP = 1'b0;
`endif

    typedef struct {
        logic [VEC_W-1:0] row;
        logic [VEC_W-1:0] col;
    } pair_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              keep_a;
    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [VEC_W-1:0]  row;
    logic [VEC_W-1:0]  column;
    logic              validin;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    logic [WORD_W-1:0] mA [64];
    logic [WORD_W-1:0] mB [64];
    bit                aValid = 1'b0;
    pair_t             expQ [$];
    logic [VEC_W-1:0]  capRow [$];
    logic [VEC_W-1:0]  capCol [$];
    logic [VEC_W-1:0]  lastRow = '0;
    logic [VEC_W-1:0]  lastCol = '0;
    logic              rstAtEdge;

    always #5 clk = ~clk;

    matrix_operand_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef KEEP_A_EN
        .keep_a   (keep_a),
`endif
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .row      (row),
        .column   (column),
        .validin  (validin),
        .busy     (busy),
        .done     (done)
    );

    task automatic checkOutput(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Pair t of C = A*B: row i = t/8 of A, column j = t%8 of B.
    function automatic pair_t modelPair(input int t);
        pair_t p;
        int i = t / 8;
        int j = t % 8;
        for (int k = 0; k < 8; k++) begin
            p.row[32*k +: 32] = mA[8*i + k];
            p.col[32*k +: 32] = mB[8*k + j];
        end
        return p;
    endfunction

    function automatic logic [WORD_W-1:0] makeWord(input int mode, input bit isA, input int e);
        if (mode == 0) begin
            if (isA) return ((e / 8) == (e % 8)) ? 32'h3F800000 : 32'h0;
            return WORD_W'(e);
        end
        return $urandom;
    endfunction

    always @(posedge clk) rstAtEdge <= rst;

    always @(negedge clk) begin
        pair_t p;
        if (rstAtEdge === 1'b1) begin
            lastRow = '0;
            lastCol = '0;
        end
        if (validin === 1'b1) begin
            checkOutput("pair_expected", VEC_W'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
                p = expQ.pop_front();
                checkOutput("row", row, p.row);
                checkOutput("column", column, p.col);
                lastRow = p.row;
                lastCol = p.col;
                capRow.push_back(row);
                capCol.push_back(column);
            end
        end else begin
            checkOutput("row_hold", row, lastRow);
            checkOutput("column_hold", column, lastCol);
        end
    end

    // One complete operation: optional idle noise, start, word load, then 64-pair issue and done.
    task automatic applyStimulus(input bit keepA, input bit gappy, input bit interfere, input int mode, output int base);
        int  n = 0;
        int  cyc = 0;
        int  nWords;
        bit  loadA;
        logic [WORD_W-1:0] w;
        if (interfere) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
            in_valid = 1'b0;
        end
        checkOutput("idle_in_ready", in_ready, 0);
        checkOutput("idle_busy", busy, 0);
        base   = capRow.size();
        loadA  = !(HAS_KEEP && keepA && aValid);
        if (loadA) aValid = 1'b0;
        nWords = loadA ? 128 : 64;
        start  = 1'b1;
        keep_a = keepA;
        @(negedge clk);
        start  = 1'b0;
        keep_a = 1'b0;
        while (n < nWords) begin
            checkOutput("load_in_ready", in_ready, 1);
            checkOutput("load_busy", busy, 1);
            if (gappy && (cyc % 2 == 1)) begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end else begin
                if (loadA && n < 64) begin
                    w = makeWord(mode, 1'b1, n);
                    mA[n] = w;
                end else begin
                    w = makeWord(mode, 1'b0, loadA ? n - 64 : n);
                    mB[loadA ? n - 64 : n] = w;
                end
                in_valid = 1'b1;
                in_data  = w;
                n++;
                if (loadA && n == 64) aValid = 1'b1;
            end
            if (n == nWords) begin
                for (int t = 0; t < 64; t++) expQ.push_back(modelPair(t));
            end
            @(negedge clk);
            cyc++;
        end
        for (int t = 0; t < 64; t++) begin
            if (interfere) begin
                start    = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
                in_data  = $urandom;
            end else begin
                in_valid = 1'b0;
            end
            checkOutput("issue_validin", validin, 1);
            checkOutput("issue_in_ready", in_ready, 0);
            checkOutput("issue_busy", busy, 1);
            checkOutput("issue_done", done, 0);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        checkOutput("done_pulse", done, 1);
        checkOutput("done_validin", validin, 0);
        checkOutput("done_busy", busy, 1);
        @(negedge clk);
        checkOutput("after_done", done, 0);
        checkOutput("after_busy", busy, 0);
        checkOutput("after_in_ready", in_ready, 0);
    endtask

    initial begin
        int b;
        logic [VEC_W-1:0] pin;
        rst = 1'b1; start = 1'b0; keep_a = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("reset_in_ready", in_ready, 0);
            checkOutput("reset_validin", validin, 0);
            checkOutput("reset_busy", busy, 0);
            checkOutput("reset_done", done, 0);
            checkOutput("reset_row", row, 0);
        end

        applyStimulus(1'b0, 1'b0, 1'b0, 0, b);
        checkOutput("pin_pairs_seen", VEC_W'(capRow.size() - b), 64);
        if (capRow.size() > b + 9) begin
            checkOutput("pin_row_t0", capRow[b], {224'h0, 32'h3F800000});
            checkOutput("pin_col_t0", capCol[b],
                {32'd56, 32'd48, 32'd40, 32'd32, 32'd24, 32'd16, 32'd8, 32'd0});
            pin = {192'h0, 32'h3F800000, 32'h0};
            checkOutput("pin_row_t9", capRow[b+9], pin);
            checkOutput("pin_col_t9", capCol[b+9],
                {32'd57, 32'd49, 32'd41, 32'd33, 32'd25, 32'd17, 32'd9, 32'd1});
        end

        applyStimulus(1'b0, 1'b1, 1'b0, 1, b);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, b);

        // Abandon a load after all of A and 20 words of B.
        start = 1'b1;
        aValid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 84; n++) begin
            checkOutput("abort_in_ready", in_ready, 1);
            in_valid = 1'b1;
            in_data  = $urandom;
            if (n < 64) mA[n] = in_data; else mB[n-64] = in_data;
            @(negedge clk);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        aValid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready_rst", in_ready, 0);
        checkOutput("abort_busy_rst", busy, 0);
        checkOutput("abort_validin_rst", validin, 0);
        checkOutput("abort_done_rst", done, 0);
        checkOutput("abort_row_rst", row, 0);
        checkOutput("abort_column_rst", column, 0);
        @(negedge clk);

        applyStimulus(1'b1, 1'b0, 1'b0, 1, b);
        applyStimulus(1'b1, 1'b1, 1'b0, 1, b);
        applyStimulus(1'b0, 1'b0, 1'b0, 1, b);
        checkOutput("no_leftover_pairs", VEC_W'(expQ.size()), 0);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
